// File: rtl/crc32_stream_check.sv
// Streaming Ethernet CRC-32 engine: 1..8 bytes per beat, sof/eof framing,
// residue check, runt/abort flags and saturating good/bad frame counters.
module crc32_stream_check #(
  parameter int unsigned DATA_W    = 8,
  parameter int unsigned MIN_BYTES = 64,
  parameter int unsigned CNT_W     = 16
) (
  input  logic                                                clk,
  input  logic                                                reset,
  input  logic                                                clear,
  input  logic                                                clr_cnt,
  input  logic                                                valid,
  input  logic                                                sof,
  input  logic                                                eof,
  input  logic [((DATA_W > 8) ? $clog2(DATA_W/8) : 1)-1:0]    last_bytes,
  input  logic [DATA_W-1:0]                                   data,
  output logic [31:0]                                         crc_out,
  output logic                                                done,
  output logic                                                match,
  output logic                                                runt,
  output logic                                                abort,
  output logic [CNT_W-1:0]                                    byte_cnt,
  output logic [CNT_W-1:0]                                    good_cnt,
  output logic [CNT_W-1:0]                                    bad_cnt
);

  localparam int unsigned NB      = DATA_W / 8;
  localparam int unsigned LB_W    = (DATA_W > 8) ? $clog2(NB) : 1;
  localparam int unsigned NB_W    = $clog2(NB + 1);
  localparam logic [31:0] POLY    = 32'hEDB88320;
  localparam logic [31:0] RESIDUE = 32'hDEBB20E3;

  typedef enum logic {IDLE, FRAME} state_t;

  state_t             state_q, state_d;
  logic [31:0]        crc_d;
  logic               done_d, match_d, runt_d, abort_d;
  logic [CNT_W-1:0]   cnt_d, good_d, bad_d;

  logic               accept;
  logic [NB_W-1:0]    n;
  logic [31:0]        seed;
  logic [31:0]        crc_upd;
  logic [CNT_W-1:0]   cnt_base;
  logic [CNT_W-1:0]   cnt_sum;
  logic               good_inc;
  logic [1:0]         bad_inc;
  logic [31:0]        chain [NB+1];

  // One reflected CRC-32 byte step, LSB first.
  function automatic logic [31:0] crc_byte(input logic [31:0] c, input logic [7:0] d);
    logic [31:0] r;
    r = c;
    for (int i = 0; i < 8; i++) begin
      r = (r >> 1) ^ (POLY & {32{r[0] ^ d[i]}});
    end
    return r;
  endfunction

  function automatic logic [CNT_W-1:0] sat_add(input logic [CNT_W-1:0] c, input logic [1:0] inc);
    logic [CNT_W:0] s;
    s = {1'b0, c} + (CNT_W+1)'(inc);
    return s[CNT_W] ? {CNT_W{1'b1}} : s[CNT_W-1:0];
  endfunction

  // A beat is taken if it opens a frame or continues an open one.
  assign accept = valid && (sof || (state_q == FRAME));
  assign seed   = sof ? 32'hFFFFFFFF : ~crc_out;

  always_comb begin
    n = NB_W'(NB);
    if (eof && (last_bytes != '0)) begin
      n = NB_W'(last_bytes);
    end
  end

  assign chain[0] = seed;
  for (genvar k = 0; k < NB; k++) begin : g_lane
    assign chain[k+1] = crc_byte(chain[k], data[8*k +: 8]);
  end

  always_comb begin
    crc_upd = chain[NB];
    for (int k = 1; k <= int'(NB); k++) begin
      if (n == NB_W'(k)) begin
        crc_upd = chain[k];
      end
    end
  end

  always_comb begin
    logic [CNT_W:0] s;
    cnt_base = sof ? '0 : byte_cnt;
    s        = {1'b0, cnt_base} + (CNT_W+1)'(n);
    cnt_sum  = s[CNT_W] ? {CNT_W{1'b1}} : s[CNT_W-1:0];
  end

  // Next-state and registered-output logic.
  always_comb begin
    state_d  = state_q;
    crc_d    = crc_out;
    cnt_d    = byte_cnt;
    done_d   = 1'b0;
    abort_d  = 1'b0;
    match_d  = match;
    runt_d   = runt;
    good_d   = good_cnt;
    bad_d    = bad_cnt;
    good_inc = 1'b0;
    bad_inc  = 2'd0;

    if (clear) begin
      state_d = IDLE;
      crc_d   = 32'h0;
      cnt_d   = '0;
    end else if (accept) begin
      crc_d   = ~crc_upd;
      cnt_d   = cnt_sum;
      abort_d = sof && (state_q == FRAME);
      state_d = eof ? IDLE : FRAME;
      if (eof) begin
        done_d  = 1'b1;
        match_d = (crc_upd == RESIDUE);
        runt_d  = (32'(cnt_sum) < 32'(MIN_BYTES));
      end
    end

    good_inc = done_d && match_d && !runt_d;
    bad_inc  = 2'(abort_d) + 2'(done_d && !good_inc);

    if (clr_cnt) begin
      good_d = '0;
      bad_d  = '0;
    end else begin
      good_d = sat_add(good_cnt, 2'(good_inc));
      bad_d  = sat_add(bad_cnt, bad_inc);
    end
  end

  // crc_out holds the complemented CRC state directly; reset 0 means state all-ones.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= IDLE;
      crc_out  <= 32'h0;
      done     <= 1'b0;
      match    <= 1'b0;
      runt     <= 1'b0;
      abort    <= 1'b0;
      byte_cnt <= '0;
      good_cnt <= '0;
      bad_cnt  <= '0;
    end else begin
      state_q  <= state_d;
      crc_out  <= crc_d;
      done     <= done_d;
      match    <= match_d;
      runt     <= runt_d;
      abort    <= abort_d;
      byte_cnt <= cnt_d;
      good_cnt <= good_d;
      bad_cnt  <= bad_d;
    end
  end

endmodule

// File: doc/crc32_stream_check.md
# crc32_stream_check

Parametrised Ethernet CRC-32 engine for the GEMAC datapaths. It processes 1 to 8 bytes per clock and delimits frames with sof/eof markers. It reports the frame FCS and a residue match flag, flags runts and aborted frames, and keeps saturating good/bad frame counters. It serves the RX path, for FCS checking, and the TX path, where crc_out supplies the FCS bytes to append.

## Interface
- DATA_W, 8: beat width in bits; legal values are 8, 16, 32 and 64. NB = DATA_W/8 bytes per beat.
- MIN_BYTES, 64: minimum frame length in bytes, FCS included. Shorter frames are runts.
- CNT_W, 16: width of the byte counter and of each frame counter.
- clk  in  1  single clock; everything is rising-edge.
- reset  in  1  asynchronous, active-low reset.
- clear  in  1  synchronous abandon of the current frame; counters are retained.
- clr_cnt  in  1  synchronous zeroing of good_cnt and bad_cnt.
- valid  in  1  the beat is present this cycle. There is no backpressure.
- sof  in  1  the beat is the first beat of a frame; qualified by valid.
- eof  in  1  the beat is the last beat of a frame; qualified by valid.
- last_bytes  in  max(1,log2(NB))  number of valid bytes on the eof beat. 0 means NB. Ignored when eof=0. Valid bytes are always lanes 0 upward.
- data  in  DATA_W  byte lane k is data[8k+7:8k]. Lane 0 is the earliest on the wire; bit 0 of each byte is the first transmitted bit.
- crc_out  out  32  running FCS of the bytes accepted so far: standard reflected CRC-32, complemented. crc_out[7:0] is the first FCS byte on the wire.
- done  out  1  one-cycle pulse after the eof beat is accepted.
- match  out  1  residue check result; valid while done=1 and held until the next done.
- runt  out  1  the frame byte count was below MIN_BYTES; valid with done and held until the next done.
- abort  out  1  one-cycle pulse when sof arrives while a frame is open.
- byte_cnt  out  CNT_W  bytes accepted in the current or last frame; saturates at all-ones.
- good_cnt, bad_cnt  out  CNT_W each  saturating frame counters.

## Operation
- CRC: polynomial 0x04C11DB7, reflected form 0xEDB88320, LSB-first. The state initialises to 0xFFFFFFFF. crc_out = ~state.
- Per beat, the state advances through exactly n bytes in lane order. n is NB on a non-eof beat, or last_bytes (0 → NB) on an eof beat.
- The next-state logic is the generate-loop composition of the per-byte update for each lane count 1..NB, selected by n. A bitwise model is acceptable; a table is not required.
- States are IDLE and FRAME.
- In IDLE, a valid beat without sof is discarded: no state change, no outputs.
- In IDLE, valid&sof: the state is seeded from 0xFFFFFFFF (not the old value) and updated with the beat, and byte_cnt = n.
  - If eof is also set, the frame is a single-beat frame and the machine stays in IDLE.
  - Otherwise it goes to FRAME.
- In FRAME, valid&!sof: the state is updated and byte_cnt += n. If eof is set, the machine goes to IDLE.
- In FRAME, valid&sof: abort pulses and bad_cnt increments. The new frame then starts exactly as from IDLE; the discarded frame does not assert done.
- End of frame, registered in the cycle after the eof beat:
  - done=1.
  - match=(state==0xDEBB20E3), equivalently crc_out==0x2144DF1C.
  - runt=(byte_cnt<MIN_BYTES).
  - If match&!runt, good_cnt increments; otherwise bad_cnt increments.
- clear: state ← 0xFFFFFFFF, machine → IDLE, byte_cnt ← 0. clear takes priority over a valid beat in the same cycle; no done and no count change result.
- clr_cnt while a counter increments in the same cycle: the result is 0, and the clear wins.
- Counters and byte_cnt saturate at 2^CNT_W−1 and never wrap.
- Reset values: crc_out=0x00000000 (state all-ones), done=0, match=0, runt=0, abort=0, byte_cnt=0, good_cnt=0, bad_cnt=0; machine in IDLE.

## Timing
- All outputs are registered.
- crc_out reflects every beat accepted up to and including cycle t by cycle t+1.
- done, match, runt and the counter updates appear at t+1 for an eof beat at t.
- A new sof beat is legal in the cycle immediately after eof. Back-to-back single-beat frames give one done per cycle.
- abort appears at t+1 for the offending sof beat at t.
- Reset asserted mid-frame clears everything asynchronously. No done is produced for the interrupted frame. The first beat after deassertion is processed normally.
- The next-state cone may span up to 8 byte updates; at DATA_W=64 it must close at 125 MHz without pipelining.

## Test plan
- DATA_W=8, ASCII "123456789" (0x31..0x39), sof on the first byte, eof on the last → done at eof+1, crc_out=0xCBF43926, runt=1, bad_cnt=1.
- DATA_W=32, the same bytes as beats 0x34333231, 0x38373635, 0x00000039 with last_bytes=1 → crc_out=0xCBF43926 at done; checks the partial-beat path.
- DATA_W=64, 60-byte payload followed by its own FCS (crc_out bytes, LSB first), 64 bytes total, last_bytes=0 → match=1, crc_out=0x2144DF1C, runt=0, good_cnt=1. Flip one data bit → match=0, bad_cnt +1.
- Frame open, then sof mid-frame → abort pulse, bad_cnt +1. The second frame completes with done and a correct CRC unaffected by the first.
- reset low for one cycle mid-frame → all outputs 0 immediately, counters 0. A subsequent "123456789" frame → 0xCBF43926.
- Force good_cnt to 0xFFFF through repeated good frames (or CNT_W=2 with 4+ frames) → it holds at max. clr_cnt in the same cycle as done → the counter reads 0.
